vpg_mode_ctrl: RTL and testbench
================================

VPG_MODE_CTRL -- requirements
Module: vpg_mode_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 16'd50000, is the maximum number of clk cycles to wait for pll_locked after a reconfiguration.
REQ-002 Parameter SETTLE_CYCLES, default 8'd64, is the number of clk cycles to keep the timing generator held after lock.
REQ-003 Parameter MODE_MAX, default 4'd9, is the highest supported mode code.
REQ-004 Port clk, input, 1 bit: system clock.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port clk_en, input, 1 bit: qualifier for sampling vpg_mode_change and vpg_mode.
REQ-007 Port vpg_mode_change, input, 1 bit: mode-change request from the mode selector.
REQ-008 Port vpg_mode, input, 4 bits: requested mode code.
REQ-009 Port pll_mode, output, 4 bits: mode code presented to the PLL reconfiguration engine.
REQ-010 Port pll_reconfig_req, output, 1 bit: level request to the PLL reconfiguration engine.
REQ-011 Port pll_reconfig_done, input, 1 bit: single-cycle completion pulse from the PLL reconfiguration engine.
REQ-012 Port pll_locked, input, 1 bit: pixel PLL lock, already synchronous to clk.
REQ-013 Port timing_reset_n, output, 1 bit: active-low hold for the timing generator.
REQ-014 Port active_mode, output, 4 bits: mode currently driven to the timing generator.
REQ-015 Port mode_valid, output, 1 bit: high while video timing is running in active_mode.
REQ-016 Port mode_error, output, 1 bit: single-cycle pulse when an unsupported code is rejected.
REQ-017 Port lock_fail, output, 1 bit: sticky flag set when lock retries are exhausted.

Function
REQ-018 A change event is a clk cycle with clk_en=1 and vpg_mode_change=1; vpg_mode is sampled in that same cycle.
REQ-019 An event with vpg_mode>MODE_MAX shall pulse mode_error for one cycle and otherwise be ignored.
REQ-020 The state machine states are IDLE, BLANK, REQ, LOCK_WAIT, SETTLE, RUN, FAIL.
REQ-021 IDLE transitions to BLANK on a valid event, storing vpg_mode into the pending register.
REQ-022 In RUN, a valid event with vpg_mode equal to active_mode is ignored; any other valid event stores pending and transitions to BLANK.
REQ-023 BLANK deasserts timing_reset_n and mode_valid in the same cycle, then transitions to REQ on the next cycle.
REQ-024 On REQ entry, pll_mode is loaded from pending and pll_reconfig_req is asserted; pll_mode is held stable while the request is high.
REQ-025 REQ holds pll_reconfig_req until pll_reconfig_done=1, drops the request on the following cycle, and transitions to LOCK_WAIT.
REQ-026 LOCK_WAIT clears a 16-bit counter on entry and transitions to SETTLE on the first cycle with pll_locked=1.
REQ-027 If LOCK_WAIT sees no lock for LOCK_TIMEOUT cycles, it increments the retry counter and returns to REQ; a third timeout (retry counter=2) instead sets lock_fail and enters FAIL.
REQ-028 FAIL holds timing_reset_n=0 and exits to BLANK only on a valid event, clearing lock_fail and the retry counter.
REQ-029 SETTLE counts SETTLE_CYCLES cycles and returns to LOCK_WAIT without reconfiguration if pll_locked drops.
REQ-030 At the end of SETTLE, active_mode is loaded from pll_mode, timing_reset_n rises, mode_valid rises in the same cycle, the retry counter is cleared, and the FSM enters RUN.
REQ-031 A valid event while in BLANK or REQ before the request is issued overwrites pending (last one wins).
REQ-032 A valid event after the request is issued sets a reissue flag and stores pending; at the end of SETTLE the FSM goes to BLANK instead of RUN when the reissue flag is set.
REQ-033 A loss of pll_locked in RUN drops mode_valid and timing_reset_n next cycle and enters LOCK_WAIT without reconfiguration.
REQ-034 A change event and a lock loss in the same RUN cycle are handled by taking the change event path (BLANK).

Reset
REQ-035 While reset_n=0, the state is IDLE, active_mode=pll_mode=pending=4'd0, pll_reconfig_req=0, timing_reset_n=0, mode_valid=0, mode_error=0, lock_fail=0, and all counters and flags are 0.
REQ-036 Reset asserted mid-sequence aborts immediately (including dropping pll_reconfig_req), and no event is remembered across reset.

Verification
REQ-037 Reset release, event with mode=4'd2, done pulse 5 cycles after the request, lock at +100 -> active_mode=2, mode_valid rises 64 cycles after lock.
REQ-038 In RUN with mode 2, an event with mode 4'd2 -> no request is issued and mode_valid stays 1; an event with mode 4'd12 -> one mode_error pulse and no state change.
REQ-039 pll_locked held 0 -> pll_reconfig_req is asserted 3 times at 50000-cycle spacing, then lock_fail=1 and the FSM is in FAIL; a subsequent valid event clears lock_fail.
REQ-040 Event with mode 3 arrives during LOCK_WAIT of mode 5 -> after SETTLE, re-enter BLANK, pll_mode=3, and final active_mode=3.
REQ-041 pll_locked drops for 10 cycles in RUN -> mode_valid=0, no request is issued, and mode_valid returns 64 cycles after relock.
REQ-042 reset_n pulsed low while pll_reconfig_req=1 -> all outputs match REQ-035 within the reset cycle.

Source files
------------

// File: rtl/vpg_mode_ctrl.sv
// Video mode-change sequencer: blanks the timing generator, reconfigures the
// pixel PLL, waits for lock and settle, then releases timing in the new mode.
module vpg_mode_ctrl #(
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd50000,
  parameter logic [7:0]  SETTLE_CYCLES = 8'd64,
  parameter logic [3:0]  MODE_MAX      = 4'd9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       vpg_mode_change,
  input  logic [3:0] vpg_mode,
  output logic [3:0] pll_mode,
  output logic       pll_reconfig_req,
  input  logic       pll_reconfig_done,
  input  logic       pll_locked,
  output logic       timing_reset_n,
  output logic [3:0] active_mode,
  output logic       mode_valid,
  output logic       mode_error,
  output logic       lock_fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_BLANK, S_REQ, S_LOCK_WAIT, S_SETTLE, S_RUN, S_FAIL
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  pending;
  logic [15:0] lw_cnt;
  logic [7:0]  st_cnt;
  logic [1:0]  retry;
  logic        reissue;

  logic ev_any, ev_ok, ev_bad, lw_to, st_end, req_entry;

  assign ev_any    = clk_en & vpg_mode_change;
  assign ev_ok     = ev_any & (vpg_mode <= MODE_MAX);
  assign ev_bad    = ev_any & (vpg_mode > MODE_MAX);
  assign lw_to     = (lw_cnt == LOCK_TIMEOUT - 16'd1);
  assign st_end    = (st_cnt == SETTLE_CYCLES - 8'd1);
  assign req_entry = (state_nxt == S_REQ) && (state != S_REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ev_ok) state_nxt = S_BLANK;
      S_BLANK: state_nxt = S_REQ;
      S_REQ:   if (pll_reconfig_done) state_nxt = S_LOCK_WAIT;
      S_LOCK_WAIT: begin
        if (pll_locked)  state_nxt = S_SETTLE;
        else if (lw_to)  state_nxt = (retry == 2'd2) ? S_FAIL : S_REQ;
      end
      S_SETTLE: begin
        // An event landing on the final settle cycle must not be lost
        if (!pll_locked)  state_nxt = S_LOCK_WAIT;
        else if (st_end)  state_nxt = (reissue || ev_ok) ? S_BLANK : S_RUN;
      end
      S_RUN: begin
        if (ev_ok && (vpg_mode != active_mode)) state_nxt = S_BLANK;
        else if (!pll_locked)                   state_nxt = S_LOCK_WAIT;
      end
      S_FAIL:  if (ev_ok) state_nxt = S_BLANK;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending          <= 4'd0;
      pll_mode         <= 4'd0;
      pll_reconfig_req <= 1'b0;
      active_mode      <= 4'd0;
      timing_reset_n   <= 1'b0;
      mode_valid       <= 1'b0;
      mode_error       <= 1'b0;
      lock_fail        <= 1'b0;
      lw_cnt           <= 16'd0;
      st_cnt           <= 8'd0;
      retry            <= 2'd0;
      reissue          <= 1'b0;
    end else begin
      mode_error <= ev_bad;
      if (ev_ok && ((state != S_RUN) || (vpg_mode != active_mode)))
        pending <= vpg_mode;

      // REQ entry always issues the newest pending code, so any reissue is absorbed
      if (req_entry)
        reissue <= 1'b0;
      else if (ev_ok && (state inside {S_REQ, S_LOCK_WAIT, S_SETTLE}))
        reissue <= 1'b1;

      if (req_entry) begin
        pll_mode         <= ev_ok ? vpg_mode : pending;
        pll_reconfig_req <= 1'b1;
      end else if ((state == S_REQ) && pll_reconfig_done) begin
        pll_reconfig_req <= 1'b0;
      end

      lw_cnt <= (state == S_LOCK_WAIT) ? lw_cnt + 16'd1 : 16'd0;
      st_cnt <= (state == S_SETTLE)    ? st_cnt + 8'd1  : 8'd0;

      if ((state == S_LOCK_WAIT) && !pll_locked && lw_to && (retry != 2'd2))
        retry <= retry + 2'd1;
      else if (((state == S_FAIL) && ev_ok) || ((state == S_SETTLE) && (state_nxt == S_RUN)))
        retry <= 2'd0;

      if ((state == S_LOCK_WAIT) && (state_nxt == S_FAIL)) lock_fail <= 1'b1;
      else if ((state == S_FAIL) && ev_ok)                 lock_fail <= 1'b0;

      if ((state == S_SETTLE) && (state_nxt == S_RUN)) active_mode <= pll_mode;

      // Timing only runs in RUN; any exit drops both in the same cycle
      timing_reset_n <= (state_nxt == S_RUN);
      mode_valid     <= (state_nxt == S_RUN);
    end
  end

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// Directed bench for vpg_mode_ctrl; short lock timeout keeps the retry test brief.
module tb_vpg_mode_ctrl;

  localparam logic [15:0] LT = 16'd200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       vpg_mode_change = 1'b0;
  logic [3:0] vpg_mode = 4'd0;
  logic [3:0] pll_mode;
  logic       pll_reconfig_req;
  logic       pll_reconfig_done = 1'b0;
  logic       pll_locked = 1'b0;
  logic       timing_reset_n;
  logic [3:0] active_mode;
  logic       mode_valid;
  logic       mode_error;
  logic       lock_fail;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  vpg_mode_ctrl #(.LOCK_TIMEOUT(LT), .SETTLE_CYCLES(8'd64), .MODE_MAX(4'd9)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .vpg_mode_change(vpg_mode_change), .vpg_mode(vpg_mode),
    .pll_mode(pll_mode), .pll_reconfig_req(pll_reconfig_req),
    .pll_reconfig_done(pll_reconfig_done), .pll_locked(pll_locked),
    .timing_reset_n(timing_reset_n), .active_mode(active_mode),
    .mode_valid(mode_valid), .mode_error(mode_error), .lock_fail(lock_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_ev(input logic [3:0] m);
    vpg_mode = m;
    vpg_mode_change = 1'b1;
    tick();
    vpg_mode_change = 1'b0;
  endtask

  // Done sampled n edges after the request rose
  task automatic done_pulse(input int n);
    repeat (n - 1) tick();
    pll_reconfig_done = 1'b1;
    tick();
    pll_reconfig_done = 1'b0;
  endtask

  task automatic lock_settle(input logic [3:0] m, input string tag);
    pll_locked = 1'b1;
    tick();
    repeat (63) tick();
    chk({tag, "_mv_pre"}, 32'(mode_valid), 32'd0);
    tick();
    chk({tag, "_mv"}, 32'(mode_valid), 32'd1);
    chk({tag, "_trn"}, 32'(timing_reset_n), 32'd1);
    chk({tag, "_active"}, 32'(active_mode), 32'(m));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(pll_reconfig_req), 32'd0);
    chk({tag, "_pll_mode"}, 32'(pll_mode), 32'd0);
    chk({tag, "_active"}, 32'(active_mode), 32'd0);
    chk({tag, "_trn"}, 32'(timing_reset_n), 32'd0);
    chk({tag, "_mv"}, 32'(mode_valid), 32'd0);
    chk({tag, "_merr"}, 32'(mode_error), 32'd0);
    chk({tag, "_lfail"}, 32'(lock_fail), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise [3];
    int n;
    logic seen;

    repeat (3) tick();
    chk_all_zero("rst");
    reset_n = 1'b1;
    repeat (2) tick();

    // First mode bring-up
    send_ev(4'd2);
    chk("t1_blank_req", 32'(pll_reconfig_req), 32'd0);
    chk("t1_blank_trn", 32'(timing_reset_n), 32'd0);
    tick();
    chk("t1_req", 32'(pll_reconfig_req), 32'd1);
    chk("t1_pll_mode", 32'(pll_mode), 32'd2);
    done_pulse(5);
    chk("t1_req_drop", 32'(pll_reconfig_req), 32'd0);
    repeat (94) tick();
    lock_settle(4'd2, "t1");

    // Same-mode, clk_en=0 and unsupported events
    send_ev(4'd2);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pll_reconfig_req || !mode_valid) seen = 1'b1;
      tick();
    end
    chk("t2_same_ignored", 32'(seen), 32'd0);
    clk_en = 1'b0;
    vpg_mode = 4'd5;
    vpg_mode_change = 1'b1;
    repeat (3) tick();
    vpg_mode_change = 1'b0;
    clk_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pll_reconfig_req || !mode_valid) seen = 1'b1;
      tick();
    end
    chk("t2_clken_ignored", 32'(seen), 32'd0);
    send_ev(4'd12);
    chk("t2_merr_pulse", 32'(mode_error), 32'd1);
    tick();
    chk("t2_merr_clear", 32'(mode_error), 32'd0);
    chk("t2_mv_kept", 32'(mode_valid), 32'd1);
    chk("t2_active_kept", 32'(active_mode), 32'd2);

    // Lock loss in RUN for 10 cycles
    pll_locked = 1'b0;
    tick();
    chk("t3_mv_drop", 32'(mode_valid), 32'd0);
    chk("t3_trn_drop", 32'(timing_reset_n), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pll_reconfig_req) seen = 1'b1;
      tick();
    end
    chk("t3_no_req", 32'(seen), 32'd0);
    lock_settle(4'd2, "t3");

    // Change event together with lock loss, then a new event during LOCK_WAIT
    pll_locked = 1'b0;
    send_ev(4'd5);
    chk("t4_mv_drop", 32'(mode_valid), 32'd0);
    tick();
    chk("t4_req", 32'(pll_reconfig_req), 32'd1);
    chk("t4_pll_mode5", 32'(pll_mode), 32'd5);
    done_pulse(2);
    repeat (5) tick();
    send_ev(4'd3);
    pll_locked = 1'b1;
    repeat (64) tick();
    tick();
    chk("t4_reblank_mv", 32'(mode_valid), 32'd0);
    chk("t4_reblank_req", 32'(pll_reconfig_req), 32'd0);
    chk("t4_active_old", 32'(active_mode), 32'd2);
    tick();
    chk("t4_req2", 32'(pll_reconfig_req), 32'd1);
    chk("t4_pll_mode3", 32'(pll_mode), 32'd3);
    done_pulse(2);
    lock_settle(4'd3, "t4");

    // Last event in BLANK wins
    send_ev(4'd7);
    chk("t5_mv_drop", 32'(mode_valid), 32'd0);
    send_ev(4'd8);
    chk("t5_req", 32'(pll_reconfig_req), 32'd1);
    chk("t5_pll_mode", 32'(pll_mode), 32'd8);
    done_pulse(2);
    lock_settle(4'd8, "t5");

    // Lock never arrives: three requests, then FAIL
    pll_locked = 1'b0;
    send_ev(4'd4);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!pll_reconfig_req && n < 400) begin tick(); n++; end
      rise[k] = cyc;
      chk($sformatf("t6_req%0d", k), 32'(pll_reconfig_req), 32'd1);
      chk($sformatf("t6_pll_mode%0d", k), 32'(pll_mode), 32'd4);
      if (k > 0) chk($sformatf("t6_gap%0d", k), 32'(rise[k] - rise[k-1]), 32'(int'(LT) + 3));
      done_pulse(3);
      chk($sformatf("t6_drop%0d", k), 32'(pll_reconfig_req), 32'd0);
    end
    n = 0;
    while (!lock_fail && !pll_reconfig_req && n < 400) begin tick(); n++; end
    chk("t6_lock_fail", 32'(lock_fail), 32'd1);
    chk("t6_fail_gap", 32'(cyc - rise[2]), 32'(int'(LT) + 3));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pll_reconfig_req || timing_reset_n || mode_valid || !lock_fail) seen = 1'b1;
      tick();
    end
    chk("t6_fail_hold", 32'(seen), 32'd0);
    pll_locked = 1'b1;
    send_ev(4'd6);
    chk("t6_lock_fail_clr", 32'(lock_fail), 32'd0);
    tick();
    chk("t6_req_again", 32'(pll_reconfig_req), 32'd1);
    chk("t6_pll_mode6", 32'(pll_mode), 32'd6);
    done_pulse(2);
    lock_settle(4'd6, "t6");

    // Reset while request is high
    send_ev(4'd1);
    tick();
    chk("t7_req", 32'(pll_reconfig_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t7_async");
    repeat (2) tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pll_reconfig_req || mode_valid) seen = 1'b1;
    end
    chk("t7_no_memory", 32'(seen), 32'd0);
    chk("t7_pll_mode", 32'(pll_mode), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
